regfile_scoreboard: RTL
=======================

REGFILE_SCOREBOARD -- requirements
Module: regfile_scoreboard

Interface
REQ-001 Parameter XLEN, default 32, sets the data width of each register.
REQ-002 Parameter CNT_W, default 2, sets the width of each per-register pending counter (max in-flight writers = 2^CNT_W-1).
REQ-003 clk  input  1  single clock; all state updates on the rising edge.
REQ-004 rst_n  input  1  asynchronous, active-low reset.
REQ-005 rs1_addr, rs2_addr  input  5 each  ID-stage source register indices.
REQ-006 rs1_used, rs2_used  input  1 each  the issuing instruction actually reads rs1 / rs2.
REQ-007 rs1_data, rs2_data  output  XLEN each  source operand values.
REQ-008 issue_valid  input  1  ID stage attempts to issue an instruction this cycle.
REQ-009 issue_wr, issue_rd  input  1, 5  the issuing instruction writes register issue_rd.
REQ-010 issue_stall  output  1  the issue is refused this cycle; ID holds.
REQ-011 wb_valid  input  1  a previously issued writer retires this cycle.
REQ-012 wb_rd, wb_data  input  5, XLEN  the retiring destination and its value from the writeback mux.

Function
REQ-013 Storage: 31 XLEN-bit registers x1..x31; x0 SHALL NOT be stored and SHALL always read 0.
REQ-014 Reads SHALL be combinational: rsN_data = 0 if rsN_addr==0; else wb_data if wb_valid and wb_rd==rsN_addr; else the stored value.
REQ-015 Write: on the rising edge with wb_valid=1 and wb_rd!=0, reg[wb_rd] <= wb_data; wb_rd==0 writes nothing.
REQ-016 Each register x1..x31 SHALL have a CNT_W-bit pending counter; x0 SHALL have none and SHALL never be pending.
REQ-017 issue_fire = issue_valid and not issue_stall; inc = issue_fire and issue_wr and issue_rd!=0; dec = wb_valid and wb_rd!=0.
REQ-018 Counter update per register r: inc only -> +1; dec only -> -1; both, or neither -> unchanged.
REQ-019 Source hazard: for rsN with rsN_used=1 and rsN_addr!=0, the source is ready if cnt==0, or if cnt==1 and a bypass from REQ-014 applies this cycle; otherwise it is blocked.
REQ-020 Saturation hazard: issue_wr=1 with issue_rd!=0 and cnt[issue_rd] at maximum is blocked, unless dec for the same register occurs this cycle.
REQ-021 issue_stall SHALL be issue_valid AND (any blocked source OR saturation hazard); it SHALL be combinational and 0 when issue_valid=0.
REQ-022 Underflow: dec for a register whose cnt==0 is a protocol error; the counter SHALL stay at 0 and the data write still occurs.
REQ-023 Overflow SHALL be impossible by REQ-020; the counter never wraps.
REQ-024 Latency: a value written at edge N is readable from storage after edge N, and is bypassed to readers during the cycle before edge N.

Reset
REQ-025 While rst_n=0, x1..x31 SHALL clear to 0 and every pending counter SHALL clear to 0, asynchronously.
REQ-026 Outputs during and after reset SHALL follow REQ-014/REQ-021 from the cleared state: reads return 0 and issue_stall=0.
REQ-027 Reset asserted mid-operation SHALL discard all in-flight pending state; the first wb_valid after reset hits the REQ-022 rule.

Structure
REQ-028 Register-index width (5), the x0 index and the default XLEN SHALL live in the shared core package with the other pipeline constants.
REQ-029 One sub-module, sb_counter (a single saturating up/down counter with inc, dec and cnt), SHALL be instantiated 31 times; the data array stays inline.

Verification
REQ-030 Reset, then read rs1=5, rs2=0 -> both data 0, issue_stall=0.
REQ-031 Issue with issue_wr=1, rd=7; next cycle issue with rs1=7 used -> stall=1. Then wb_valid with rd=7, data=0xDEADBEEF in the same cycle -> stall=0, rs1_data=0xDEADBEEF.
REQ-032 Issue three writers to x3 (CNT_W=2), then a fourth -> stall=1. Repeat the fourth issue with a concurrent wb to x3 -> stall=0 and cnt stays 3.
REQ-033 wb_valid with rd=0, data=0x1234 -> x0 still reads 0, no counter changes, and no stall occurs on a later rd=0 issue.
REQ-034 Issue a writer to x9 while a wb to x9 retires on the same edge -> cnt[x9] unchanged. Then two wbs to x9 -> the second hits underflow, cnt stays 0, and the data is written.
REQ-035 Assert rst_n low for one cycle with x4 pending and holding 0x55 -> asynchronously x4 reads 0, cnt 0, and a consumer of x4 is not stalled.

Source files
------------

// File: rtl/regfile_scoreboard_pkg.sv
// regfile_scoreboard_pkg: shared core constants and types for the register file and scoreboard
package regfile_scoreboard_pkg;
  localparam int REG_AW = 5;
  localparam int NUM_REGS = 32;
  localparam int XLEN_DEF = 32;
  typedef logic [REG_AW-1:0] reg_idx_t;
  localparam reg_idx_t X0 = '0;
endpackage

// File: rtl/regfile_scoreboard_if.sv
// regfile_scoreboard_if: ID-stage read/issue and writeback signals between pipeline and scoreboard
interface regfile_scoreboard_if
  import regfile_scoreboard_pkg::*;
#(
  parameter int XLEN = XLEN_DEF
);
  reg_idx_t rs1_addr, rs2_addr, issue_rd, wb_rd;
  logic rs1_used, rs2_used, issue_valid, issue_wr, issue_stall, wb_valid;
  logic [XLEN-1:0] rs1_data, rs2_data, wb_data;
  modport master (
    output rs1_addr, rs2_addr, rs1_used, rs2_used, issue_valid, issue_wr, issue_rd,
           wb_valid, wb_rd, wb_data,
    input rs1_data, rs2_data, issue_stall
  );
  modport slave (
    input rs1_addr, rs2_addr, rs1_used, rs2_used, issue_valid, issue_wr, issue_rd,
          wb_valid, wb_rd, wb_data,
    output rs1_data, rs2_data, issue_stall
  );
endinterface

// File: rtl/regfile_scoreboard_sb_counter.sv
// sb_counter: pending-writer counter that saturates at both ends; inc and dec together cancel
module sb_counter #(
  parameter int CNT_W = 2
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             inc,
  input  logic             dec,
  output logic [CNT_W-1:0] cnt
);
  logic [CNT_W-1:0] cnt_d, cnt_q;
  // next count: step up or down unless already at the rail in that direction
  always_comb
    cnt_d = (inc && !dec && cnt_q != '1) ? cnt_q + CNT_W'(1) :
            (dec && !inc && cnt_q != '0) ? cnt_q - CNT_W'(1) : cnt_q;
  // count register, cleared asynchronously
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) cnt_q <= '0;
    else cnt_q <= cnt_d;
  assign cnt = cnt_q;
endmodule

// File: rtl/regfile_scoreboard.sv
// regfile_scoreboard: 31-entry register file with writeback bypass and per-register pending-writer scoreboard
module regfile_scoreboard
  import regfile_scoreboard_pkg::*;
#(
  parameter int XLEN = XLEN_DEF,
  parameter int CNT_W = 2
) (
  input logic clk,
  input logic rst_n,
  regfile_scoreboard_if.slave bus
);
  localparam logic [CNT_W-1:0] CNT_MAX = '1;
  localparam logic [CNT_W-1:0] CNT_ONE = CNT_W'(1);
  logic [XLEN-1:0] regs_q [1:NUM_REGS-1];
  logic [XLEN-1:0] regs_d [1:NUM_REGS-1];
  logic [NUM_REGS-1:0][CNT_W-1:0] cnt;
  logic byp1, byp2, blk1, blk2, sat, fire;
  // operand reads: x0 is hard zero, a same-cycle writeback bypasses storage
  always_comb begin
    byp1 = bus.wb_valid && bus.wb_rd == bus.rs1_addr;
    byp2 = bus.wb_valid && bus.wb_rd == bus.rs2_addr;
    bus.rs1_data = bus.rs1_addr == X0 ? '0 : byp1 ? bus.wb_data : regs_q[bus.rs1_addr];
    bus.rs2_data = bus.rs2_addr == X0 ? '0 : byp2 ? bus.wb_data : regs_q[bus.rs2_addr];
  end
  // hazards: a source waits on pending writers unless the last one retires now; a full counter refuses another writer
  always_comb begin
    blk1 = bus.rs1_used && bus.rs1_addr != X0 && cnt[bus.rs1_addr] != '0 &&
           !(cnt[bus.rs1_addr] == CNT_ONE && byp1);
    blk2 = bus.rs2_used && bus.rs2_addr != X0 && cnt[bus.rs2_addr] != '0 &&
           !(cnt[bus.rs2_addr] == CNT_ONE && byp2);
    sat = bus.issue_wr && bus.issue_rd != X0 && cnt[bus.issue_rd] == CNT_MAX &&
          !(bus.wb_valid && bus.wb_rd == bus.issue_rd);
    bus.issue_stall = bus.issue_valid && (blk1 || blk2 || sat);
    fire = bus.issue_valid && !bus.issue_stall;
  end
  assign cnt[0] = '0;
  for (genvar r = 1; r < NUM_REGS; r++) begin : g_cnt
    sb_counter #(.CNT_W(CNT_W)) u_cnt (
      .clk  (clk),
      .rst_n(rst_n),
      .inc  (fire && bus.issue_wr && bus.issue_rd == reg_idx_t'(r)),
      .dec  (bus.wb_valid && bus.wb_rd == reg_idx_t'(r)),
      .cnt  (cnt[r])
    );
  end
  // writeback: update the addressed register, x0 writes are dropped
  always_comb begin
    regs_d = regs_q;
    if (bus.wb_valid && bus.wb_rd != X0) regs_d[bus.wb_rd] = bus.wb_data;
  end
  // storage, cleared asynchronously
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) for (int i = 1; i < NUM_REGS; i++) regs_q[i] <= '0;
    else regs_q <= regs_d;
endmodule
